// File: rtl/frame_strobe_writer.sv
// frame_strobe_writer
//   Writing end of one fabric column's FrameData/FrameStrobe bus. Each
//   accepted word is driven onto FrameData and held stable for SetupCycles.
//   One FrameStrobe bit is then pulsed for StrobeCycles. FrameData is held
//   for a further HoldCycles before the next word is accepted.
//
// Ports
//   UserCLK        clock, rising edge
//   resetn         synchronous active-low reset
//   cfg_valid      frame word offered
//   cfg_ready      high only while IDLE (registered)
//   cfg_frame_idx  strobe line to pulse for this word
//   cfg_data       frame data word
//   FrameData      registered frame data to the column
//   FrameStrobe    registered one-hot strobe, zero outside STROBE
//   busy           high in any non-IDLE state
//   err_bad_idx    one-cycle pulse when a word with an out-of-range index is dropped
//   frames_written completed strobes, wraps at 16 bits
module frame_strobe_writer #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int FrameIdxWidth   = 5,
    parameter int SetupCycles     = 1,
    parameter int StrobeCycles    = 1,
    parameter int HoldCycles      = 1
) (
    input  logic                       UserCLK,
    input  logic                       resetn,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [FrameIdxWidth-1:0]   cfg_frame_idx,
    input  logic [FrameBitsPerRow-1:0] cfg_data,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       err_bad_idx,
    output logic [15:0]                frames_written
);

    localparam int MaxCyc = (SetupCycles > StrobeCycles)
                          ? ((SetupCycles > HoldCycles) ? SetupCycles : HoldCycles)
                          : ((StrobeCycles > HoldCycles) ? StrobeCycles : HoldCycles);
    // Counter only has to reach MaxCyc-1 before it is cleared.
    localparam int CntW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t                     state_q, state_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [FrameIdxWidth-1:0]   idx_q, idx_d;
    logic [FrameBitsPerRow-1:0] data_d;
    logic [MaxFramesPerCol-1:0] strobe_d, onehot;
    logic                       err_d;
    logic [15:0]                fw_d;
    logic                       idx_ok;

    assign idx_ok = int'(cfg_frame_idx) < MaxFramesPerCol;
    assign onehot = MaxFramesPerCol'(1) << idx_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = FrameData;
        strobe_d = '0;
        err_d    = 1'b0;
        fw_d     = frames_written;
        case (state_q)
            IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    if (idx_ok) begin
                        data_d  = cfg_data;
                        idx_d   = cfg_frame_idx;
                        cnt_d   = '0;
                        state_d = SETUP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                // The strobe register is loaded on the leaving edge so it
                // rises exactly when STROBE is entered.
                if (cnt_q == CntW'(SetupCycles - 1)) begin
                    cnt_d    = '0;
                    state_d  = STROBE;
                    strobe_d = onehot;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STROBE: begin
                if (cnt_q == CntW'(StrobeCycles - 1)) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                    fw_d    = frames_written + 16'd1;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    strobe_d = onehot;
                end
            end
            HOLD: begin
                if (cnt_q == CntW'(HoldCycles - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge UserCLK) begin
        if (!resetn) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            idx_q          <= '0;
            FrameData      <= '0;
            FrameStrobe    <= '0;
            cfg_ready      <= 1'b1;
            busy           <= 1'b0;
            err_bad_idx    <= 1'b0;
            frames_written <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            FrameData      <= data_d;
            FrameStrobe    <= strobe_d;
            cfg_ready      <= (state_d == IDLE);
            busy           <= (state_d != IDLE);
            err_bad_idx    <= err_d;
            frames_written <= fw_d;
        end
    end

endmodule

// File: tb/tb_frame_strobe_writer.sv
// Testbench for frame_strobe_writer: default instance (table vectors,
// scoreboard, back-to-back, bad index, wrap), StrobeCycles=3 instance
// (reset mid-strobe), and Setup/Strobe/Hold=(2,3,4) instance (timing sweep).
module tb_frame_strobe_writer;
    localparam int M  = 20;
    localparam int W  = 32;
    localparam int IW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn   [3];
    logic          vld    [3];
    logic [IW-1:0] idx;
    logic [W-1:0]  data;
    logic          ready  [3];
    logic [W-1:0]  fdata  [3];
    logic [M-1:0]  strobe [3];
    logic          busy   [3];
    logic          err    [3];
    logic [15:0]   cnt    [3];

    frame_strobe_writer dut0 (
        .UserCLK(clk), .resetn(rstn[0]), .cfg_valid(vld[0]), .cfg_ready(ready[0]),
        .cfg_frame_idx(idx), .cfg_data(data), .FrameData(fdata[0]), .FrameStrobe(strobe[0]),
        .busy(busy[0]), .err_bad_idx(err[0]), .frames_written(cnt[0]));

    frame_strobe_writer #(.SetupCycles(1), .StrobeCycles(3), .HoldCycles(1)) dut1 (
        .UserCLK(clk), .resetn(rstn[1]), .cfg_valid(vld[1]), .cfg_ready(ready[1]),
        .cfg_frame_idx(idx), .cfg_data(data), .FrameData(fdata[1]), .FrameStrobe(strobe[1]),
        .busy(busy[1]), .err_bad_idx(err[1]), .frames_written(cnt[1]));

    frame_strobe_writer #(.SetupCycles(2), .StrobeCycles(3), .HoldCycles(4)) dut2 (
        .UserCLK(clk), .resetn(rstn[2]), .cfg_valid(vld[2]), .cfg_ready(ready[2]),
        .cfg_frame_idx(idx), .cfg_data(data), .FrameData(fdata[2]), .FrameStrobe(strobe[2]),
        .busy(busy[2]), .err_bad_idx(err[2]), .frames_written(cnt[2]));

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [M-1:0] strobe;
        logic [W-1:0] data;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [IW-1:0] idx;
        logic [W-1:0]  data;
        bit            bad;
    } vec_t;
    vec_t vecs[6];

    logic [15:0] exp_cnt   = '0;
    logic [W-1:0] last_good = '0;
    bit  mon_en    = 1'b0;
    int  last_stb  = -100;
    int  stb_gap   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [M-1:0] oh(input logic [IW-1:0] i);
        logic [M-1:0] r;
        r = 1;
        return r << i;
    endfunction

    task automatic wait_ready(input int sel);
        int n = 0;
        while (!ready[sel] && n < 50) begin
            tick();
            n++;
        end
        if (!ready[sel]) chk("ready_timeout", 32'(ready[sel]), 1);
    endtask

    // Scoreboard monitor on the default instance: pops on each strobe rise.
    initial begin
        logic [M-1:0] pstb;
        logic [W-1:0] pdat;
        exp_t e;
        pstb = '0;
        pdat = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (strobe[0] != '0 && pstb == '0) begin
                    if (sbq.size() == 0) begin
                        chk("sb_unexpected_strobe", 32'(strobe[0]), 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("sb_strobe", 32'(strobe[0]), 32'(e.strobe));
                        chk("sb_data", fdata[0], e.data);
                    end
                    stb_gap  = cyc - last_stb;
                    last_stb = cyc;
                end
                if ($countones(strobe[0]) > 1) chk("strobe_onehot", $countones(strobe[0]), 1);
                if (strobe[0] != pstb) chk("data_stable_at_strobe_edge", fdata[0], pdat);
                pstb = strobe[0];
                pdat = fdata[0];
            end
        end
    end

    task automatic do_write(input logic [IW-1:0] i, input logic [W-1:0] d, input bit bad);
        wait_ready(0);
        idx    = i;
        data   = d;
        vld[0] = 1'b1;
        if (!bad) sbq.push_back('{strobe: oh(i), data: d});
        tick();
        vld[0] = 1'b0;
        if (bad) begin
            chk("bad_err_pulse", 32'(err[0]), 1);
            chk("bad_ready", 32'(ready[0]), 1);
            chk("bad_data_kept", fdata[0], last_good);
            chk("bad_no_strobe", 32'(strobe[0]), 0);
            tick();
            chk("bad_err_clear", 32'(err[0]), 0);
        end else begin
            chk("wr_data", fdata[0], d);
            chk("wr_ready_low", 32'(ready[0]), 0);
            chk("wr_busy", 32'(busy[0]), 1);
            last_good = d;
            exp_cnt   = exp_cnt + 16'd1;
        end
        wait_ready(0);
        chk("frames_written", 32'(cnt[0]), 32'(exp_cnt));
    endtask

    // Checks every cycle after the handshake edge (k = edges since handshake).
    task automatic timed_write(input int sel, input int s, input int t, input int h,
                               input logic [IW-1:0] i, input logic [W-1:0] d);
        logic [M-1:0] es;
        wait_ready(sel);
        idx      = i;
        data     = d;
        vld[sel] = 1'b1;
        if (sel == 0) begin
            sbq.push_back('{strobe: oh(i), data: d});
            last_good = d;
            exp_cnt   = exp_cnt + 16'd1;
        end
        tick();
        vld[sel] = 1'b0;
        for (int k = 0; k <= s + t + h; k++) begin
            es = (k >= s && k < s + t) ? oh(i) : '0;
            chk($sformatf("t%0d_strobe_k%0d", sel, k), 32'(strobe[sel]), 32'(es));
            chk($sformatf("t%0d_ready_k%0d", sel, k), 32'(ready[sel]), 32'(k == s + t + h));
            chk($sformatf("t%0d_data_k%0d", sel, k), fdata[sel], d);
            if (k < s + t + h) tick();
        end
    endtask

    initial begin
        vecs[0] = '{idx: 5'd3,  data: 32'hCAFEF00D, bad: 1'b0};
        vecs[1] = '{idx: 5'd20, data: 32'h0000AAAA, bad: 1'b1};
        vecs[2] = '{idx: 5'd11, data: 32'h12345678, bad: 1'b0};
        vecs[3] = '{idx: 5'd31, data: 32'h00005555, bad: 1'b1};
        vecs[4] = '{idx: 5'd19, data: 32'hFFFFFFFF, bad: 1'b0};
        vecs[5] = '{idx: 5'd0,  data: 32'h00000000, bad: 1'b0};

        for (int s = 0; s < 3; s++) begin
            rstn[s] = 1'b0;
            vld[s]  = 1'b0;
        end
        idx  = '0;
        data = '0;
        @(negedge clk);
        tick();
        tick();
        for (int s = 0; s < 3; s++) rstn[s] = 1'b1;

        chk("rst_strobe", 32'(strobe[0]), 0);
        chk("rst_data", fdata[0], 0);
        chk("rst_ready", 32'(ready[0]), 1);
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_err", 32'(err[0]), 0);
        chk("rst_count", 32'(cnt[0]), 0);
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("idle_quiet", {fdata[0][11:0], strobe[0]},
                {12'h000, 20'h00000});
            chk("idle_ready", 32'(ready[0]), 1);
        end
        mon_en = 1'b1;

        // Single write with the default timing.
        timed_write(0, 1, 1, 1, 5'd7, 32'hDEADBEEF);
        chk("single_strobe_bit7", 32'(oh(5'd7)), 32'h00080);
        chk("single_count", 32'(cnt[0]), 1);

        // Table-driven vectors.
        for (int v = 0; v < 6; v++) do_write(vecs[v].idx, vecs[v].data, vecs[v].bad);

        // Back-to-back with cfg_valid held high.
        wait_ready(0);
        idx    = 5'd0;
        data   = 32'h1;
        vld[0] = 1'b1;
        sbq.push_back('{strobe: oh(5'd0), data: 32'h1});
        sbq.push_back('{strobe: oh(5'd19), data: 32'h2});
        tick();
        idx  = 5'd19;
        data = 32'h2;
        for (int n = 0; n < 20 && fdata[0] != 32'h2; n++) tick();
        vld[0] = 1'b0;
        chk("b2b_second_accepted", fdata[0], 32'h2);
        exp_cnt   = exp_cnt + 16'd2;
        last_good = 32'h2;
        wait_ready(0);
        chk("b2b_gap", stb_gap, 4);
        chk("b2b_count", 32'(cnt[0]), 32'(exp_cnt));

        // Consecutive bad words give consecutive error pulses.
        idx    = 5'd20;
        vld[0] = 1'b1;
        tick();
        chk("bad1_err", 32'(err[0]), 1);
        idx = 5'd31;
        tick();
        vld[0] = 1'b0;
        chk("bad2_err", 32'(err[0]), 1);
        chk("bad2_ready", 32'(ready[0]), 1);
        tick();
        chk("bad_err_end", 32'(err[0]), 0);
        chk("bad_data_unchanged", fdata[0], last_good);
        chk("bad_count_unchanged", 32'(cnt[0]), 32'(exp_cnt));

        // Counter wrap via preload.
        force dut0.frames_written = 16'hFFFE;
        tick();
        release dut0.frames_written;
        tick();
        chk("wrap_preload", 32'(cnt[0]), 32'hFFFE);
        exp_cnt = 16'hFFFE;
        do_write(5'd1, 32'hA5A5A5A5, 1'b0);
        chk("wrap_ffff", 32'(cnt[0]), 32'hFFFF);
        do_write(5'd2, 32'h5A5A5A5A, 1'b0);
        chk("wrap_zero", 32'(cnt[0]), 32'h0000);

        // Reset during the second strobe cycle (StrobeCycles=3).
        wait_ready(1);
        idx    = 5'd3;
        data   = 32'h33;
        vld[1] = 1'b1;
        tick();
        vld[1] = 1'b0;
        tick();
        tick();
        chk("midrst_strobe_before", 32'(strobe[1]), 32'(oh(5'd3)));
        rstn[1] = 1'b0;
        tick();
        rstn[1] = 1'b1;
        chk("midrst_strobe_off", 32'(strobe[1]), 0);
        chk("midrst_count", 32'(cnt[1]), 0);
        chk("midrst_ready", 32'(ready[1]), 1);
        chk("midrst_busy", 32'(busy[1]), 0);
        timed_write(1, 1, 3, 1, 5'd5, 32'h55AA55AA);
        chk("midrst_next_count", 32'(cnt[1]), 1);

        // Timing sweep Setup/Strobe/Hold = 2/3/4.
        timed_write(2, 2, 3, 4, 5'd9, 32'h0BADCAFE);
        chk("sweep_count", 32'(cnt[2]), 1);

        tick();
        chk("sb_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/frame_strobe_writer.md
Name: frame_strobe_writer

Overview:
Configuration-side driver for one fabric column's frame interface: the writing end of the FrameData/FrameStrobe bus that terminal and fabric tiles buffer and forward.
- Accepts frame words over a valid/ready stream.
- Drives FrameData stable, then pulses exactly one FrameStrobe bit for the addressed frame, then holds data for a guard period.
- Sits between the bitstream loader and the bottom of a fabric column.

Parameters:
MaxFramesPerCol, 20, number of FrameStrobe lines per column
FrameBitsPerRow, 32, FrameData width
FrameIdxWidth, 5, width of frame index input; must satisfy 2**FrameIdxWidth >= MaxFramesPerCol
SetupCycles, 1, cycles FrameData is stable before strobe (>=1)
StrobeCycles, 1, cycles the strobe bit is high (>=1)
HoldCycles, 1, cycles FrameData is held after strobe falls (>=1)

Ports:
UserCLK  input  1  sole clock, rising edge
resetn  input  1  synchronous active-low reset
cfg_valid  input  1  frame word offered
cfg_ready  output  1  writer can accept a word
cfg_frame_idx  input  FrameIdxWidth  target frame (strobe line) index
cfg_data  input  FrameBitsPerRow  frame data word
FrameData  output  FrameBitsPerRow  registered frame data to the column
FrameStrobe  output  MaxFramesPerCol  registered one-hot strobe, all-zero when idle
busy  output  1  high in any non-IDLE state
err_bad_idx  output  1  one-cycle pulse on rejected index
frames_written  output  16  count of completed strobes, wraps 0xFFFF->0

Behaviour:
- Reset (resetn=0 at rising edge): state=IDLE, FrameData=0, FrameStrobe=0, cfg_ready=1, busy=0, err_bad_idx=0, frames_written=0, internal counters=0.
- Reset mid-operation: on that edge FrameStrobe drops to 0 and the in-flight frame is abandoned; frames_written is not incremented.
- All outputs are registered. cfg_ready is high only in IDLE.
- A handshake is cfg_valid & cfg_ready at a rising edge.
- IDLE, handshake with cfg_frame_idx < MaxFramesPerCol:
  - FrameData <= cfg_data; index latched; cycle counter <= 0.
  - Go to SETUP; cfg_ready=0 and busy=1 from the next cycle.
- IDLE, handshake with cfg_frame_idx >= MaxFramesPerCol:
  - Word dropped; FrameData unchanged.
  - err_bad_idx=1 for exactly the next cycle; stay IDLE with cfg_ready=1.
  - Back-to-back bad words give consecutive pulses.
- SETUP: FrameStrobe=0, FrameData stable. After SetupCycles cycles go to STROBE.
- STROBE: FrameStrobe = one-hot(latched idx); other bits 0. After StrobeCycles cycles go to HOLD.
- HOLD: FrameStrobe=0, FrameData stable. frames_written increments on the STROBE->HOLD edge. After HoldCycles cycles go to IDLE.
- Timing with the handshake at edge 0:
  - FrameStrobe high during cycles SetupCycles+1 .. SetupCycles+StrobeCycles.
  - cfg_ready returns high in cycle SetupCycles+StrobeCycles+HoldCycles+1.
  - With defaults: strobe in cycle 2, ready again in cycle 4, so one frame takes 4 cycles per word.
- FrameData keeps its last value in IDLE; it is not cleared between frames.
- cfg_valid, cfg_data and cfg_frame_idx are ignored while cfg_ready=0. No queuing; the upstream holds its word.
- FrameStrobe never has more than one bit set, and never changes in the same cycle as FrameData.
- Cycle counter width is sized to max(SetupCycles, StrobeCycles, HoldCycles).

Test Plan:
- Reset then idle: resetn low 2 cycles -> FrameStrobe=0, FrameData=0, cfg_ready=1, frames_written=0; nothing changes for 10 idle cycles.
- Single write, defaults: idx=7, data=0xDEADBEEF at edge 0 -> FrameData=0xDEADBEEF from cycle 1; FrameStrobe=0x00080 only in cycle 2; cfg_ready=1 in cycle 4; frames_written=1.
- Back-to-back with cfg_valid held: idx 0 then 19, data 0x1/0x2 -> strobes 0x00001 then 0x80000, 4 cycles apart; FrameData=0x2 never overlaps bit 0 strobe; count=2.
- Bad index: idx=20, then idx=31 -> err_bad_idx pulses twice; no strobe; FrameData unchanged; count unchanged; cfg_ready stays 1.
- Reset mid-strobe, StrobeCycles=3: assert resetn=0 in the second strobe cycle -> FrameStrobe=0 next cycle; count=0; cfg_ready=1; a next write to idx=5 completes normally.
- Counter wrap (force or preload via 65536 writes) -> frames_written goes 0xFFFF then 0x0000; parameter sweep Setup/Strobe/Hold=(2,3,4) -> strobe cycles 3..5, ready at cycle 10.
